// File: rtl/find_max_stream_if.sv
// Beat-in / window-result bus of the streaming max-finder.
// The producer side (master) drives pipe_en and the beat; the finder (slave) returns window results.
interface find_max_stream_if #(
  parameter int WIDTH      = 6,
  parameter int NUM_INPUTS = 64,
  parameter int BEAT_W     = 4
);
  localparam int LVL   = $clog2(NUM_INPUTS);
  localparam int IDX_W = BEAT_W + LVL;

  logic                        pipe_en;
  logic                        i_valid;
  logic                        i_last;
  logic [WIDTH*NUM_INPUTS-1:0] i_data;
  logic                        o_valid;
  logic [WIDTH-1:0]            o_result;
  logic [IDX_W-1:0]            o_index;
  logic                        o_overflow;

  modport master (
    output pipe_en, i_valid, i_last, i_data,
    input  o_valid, o_result, o_index, o_overflow
  );

  modport slave (
    input  pipe_en, i_valid, i_last, i_data,
    output o_valid, o_result, o_index, o_overflow
  );
endinterface

// File: rtl/find_max_stream.sv
// Streaming max/argmax: registered pairwise tree per beat, then a window accumulator
// delimited by i_last. Ties resolve to the lowest lane and then the earliest beat.
module find_max_stream_node #(
  parameter int WIDTH  = 6,
  parameter int IW     = 6,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] a_val_i,
  input  logic [WIDTH-1:0] b_val_i,
  input  logic [IW-1:0]    a_idx_i,
  input  logic [IW-1:0]    b_idx_i,
  output logic [WIDTH-1:0] val_o,
  output logic [IW-1:0]    idx_o
);
  logic             b_gt;
  logic [WIDTH-1:0] val_q;
  logic [IW-1:0]    idx_q;

  // b is the higher lane, so it only wins when strictly greater
  if (SIGNED != 0) begin : g_sgn
    assign b_gt = $signed(b_val_i) > $signed(a_val_i);
  end else begin : g_uns
    assign b_gt = b_val_i > a_val_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      idx_q <= '0;
    end else if (en_i) begin
      val_q <= b_gt ? b_val_i : a_val_i;
      idx_q <= b_gt ? b_idx_i : a_idx_i;
    end
  end

  assign val_o = val_q;
  assign idx_o = idx_q;
endmodule

module find_max_stream #(
  parameter int WIDTH      = 6,
  parameter int NUM_INPUTS = 64,
  parameter int SIGNED     = 0,
  parameter int BEAT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  find_max_stream_if.slave  bus
);
  localparam int LVL   = $clog2(NUM_INPUTS);
  localparam int IDX_W = BEAT_W + LVL;
  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

  typedef enum logic {IDLE, ACC} state_t;

  logic [NUM_INPUTS-1:0][WIDTH-1:0] lane_q;
  logic [LVL:0]                     vld_pipe_q;
  logic [LVL:0]                     last_pipe_q;
  logic [LVL:0]                     ovf_pipe_q;
  logic [LVL:0][BEAT_W-1:0]         beat_pipe_q;
  logic [BEAT_W-1:0]                beat_cnt_q;
  logic                             sat_q;

  logic [WIDTH-1:0] tv_val [0:LVL][0:NUM_INPUTS-1];
  logic [LVL-1:0]   tv_idx [0:LVL][0:NUM_INPUTS-1];

  state_t           state_q;
  logic [WIDTH-1:0] acc_val_q, tree_val, sel_val_d;
  logic [IDX_W-1:0] acc_idx_q, tree_idx, sel_idx_d;
  logic             ovf_q, sel_ovf_d;
  logic             o_valid_q, o_ovf_q;
  logic [WIDTH-1:0] o_result_q;
  logic [IDX_W-1:0] o_index_q;

  function automatic logic is_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Entry stage: lanes, beat tag and per-beat overflow flag travel with the valid bit
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q      <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      ovf_pipe_q  <= '0;
      beat_pipe_q <= '0;
      beat_cnt_q  <= '0;
      sat_q       <= 1'b0;
    end else if (bus.pipe_en) begin
      lane_q      <= bus.i_data;
      vld_pipe_q  <= {vld_pipe_q[LVL-1:0], bus.i_valid};
      last_pipe_q <= {last_pipe_q[LVL-1:0], bus.i_valid & bus.i_last};
      ovf_pipe_q  <= {ovf_pipe_q[LVL-1:0], bus.i_valid & sat_q};
      beat_pipe_q <= {beat_pipe_q[LVL-1:0], beat_cnt_q};
      if (bus.i_valid) begin
        if (bus.i_last) begin
          beat_cnt_q <= '0;
          sat_q      <= 1'b0;
        end else if (beat_cnt_q == BEAT_MAX) begin
          sat_q <= 1'b1;
        end else begin
          beat_cnt_q <= beat_cnt_q + 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_leaf
    assign tv_val[0][k] = lane_q[k];
    assign tv_idx[0][k] = LVL'(k);
  end

  // Level l holds NUM_INPUTS>>l live nodes; the remaining slots are tied off
  for (genvar l = 1; l <= LVL; l++) begin : g_lvl
    for (genvar n = 0; n < NUM_INPUTS; n++) begin : g_slot
      if (n < (NUM_INPUTS >> l)) begin : g_cmp
        find_max_stream_node #(
          .WIDTH  (WIDTH),
          .IW     (LVL),
          .SIGNED (SIGNED)
        ) u_node (
          .clk     (clk),
          .rst     (rst),
          .en_i    (bus.pipe_en),
          .a_val_i (tv_val[l-1][2*n]),
          .b_val_i (tv_val[l-1][2*n+1]),
          .a_idx_i (tv_idx[l-1][2*n]),
          .b_idx_i (tv_idx[l-1][2*n+1]),
          .val_o   (tv_val[l][n]),
          .idx_o   (tv_idx[l][n])
        );
      end else begin : g_pad
        assign tv_val[l][n] = '0;
        assign tv_idx[l][n] = '0;
      end
    end
  end

  assign tree_val = tv_val[LVL][0];
  assign tree_idx = {beat_pipe_q[LVL], tv_idx[LVL][0]};

  // Accumulator keeps the incumbent on ties, so the earliest beat wins
  always_comb begin
    sel_val_d = acc_val_q;
    sel_idx_d = acc_idx_q;
    sel_ovf_d = ovf_pipe_q[LVL] | ((state_q == ACC) & ovf_q);
    if (state_q == IDLE || is_gt(tree_val, acc_val_q)) begin
      sel_val_d = tree_val;
      sel_idx_d = tree_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_val_q  <= '0;
      acc_idx_q  <= '0;
      ovf_q      <= 1'b0;
      o_valid_q  <= 1'b0;
      o_result_q <= '0;
      o_index_q  <= '0;
      o_ovf_q    <= 1'b0;
    end else if (bus.pipe_en) begin
      o_valid_q <= 1'b0;
      if (vld_pipe_q[LVL]) begin
        if (last_pipe_q[LVL]) begin
          o_valid_q  <= 1'b1;
          o_result_q <= sel_val_d;
          o_index_q  <= sel_idx_d;
          o_ovf_q    <= sel_ovf_d;
          ovf_q      <= 1'b0;
          state_q    <= IDLE;
        end else begin
          acc_val_q <= sel_val_d;
          acc_idx_q <= sel_idx_d;
          ovf_q     <= sel_ovf_d;
          state_q   <= ACC;
        end
      end
    end
  end

  assign bus.o_valid    = o_valid_q;
  assign bus.o_result   = o_result_q;
  assign bus.o_index    = o_index_q;
  assign bus.o_overflow = o_ovf_q;
endmodule

// File: tb/tb_find_max_stream.sv
// Directed bench for find_max_stream: unsigned and signed instances share one stimulus stream.
module tb_find_max_stream;
  localparam int W  = 6;
  localparam int NI = 64;
  localparam int BW = 4;
  localparam int IW = 10;

  typedef struct packed {
    logic [W-1:0]  r;
    logic [IW-1:0] x;
    logic          v;
    logic [31:0]   c;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pipe_en = 1'b1;
  logic i_valid = 1'b0;
  logic i_last = 1'b0;
  logic [W*NI-1:0] i_data = '0;

  always #5 clk = ~clk;

  find_max_stream_if #(.WIDTH(W), .NUM_INPUTS(NI), .BEAT_W(BW)) bu ();
  find_max_stream_if #(.WIDTH(W), .NUM_INPUTS(NI), .BEAT_W(BW)) bs ();

  assign bu.pipe_en = pipe_en;
  assign bu.i_valid = i_valid;
  assign bu.i_last  = i_last;
  assign bu.i_data  = i_data;
  assign bs.pipe_en = pipe_en;
  assign bs.i_valid = i_valid;
  assign bs.i_last  = i_last;
  assign bs.i_data  = i_data;

  find_max_stream #(.WIDTH(W), .NUM_INPUTS(NI), .SIGNED(0), .BEAT_W(BW)) dut_u (
    .clk (clk), .rst (rst), .bus (bu));
  find_max_stream #(.WIDTH(W), .NUM_INPUTS(NI), .SIGNED(1), .BEAT_W(BW)) dut_s (
    .clk (clk), .rst (rst), .bus (bs));

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  res_t qu[$];
  res_t qs[$];
  logic [W+IW:0] exp_u[$];
  logic [W+IW:0] exp_s[$];

  always @(posedge clk) cyc <= cyc + 1;

  // A result counts only while the consumer advances the pipe
  always @(negedge clk) begin
    if (!rst && pipe_en) begin
      if (bu.o_valid) qu.push_back('{r: bu.o_result, x: bu.o_index, v: bu.o_overflow, c: cyc});
      if (bs.o_valid) qs.push_back('{r: bs.o_result, x: bs.o_index, v: bs.o_overflow, c: cyc});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [W*NI-1:0] d, input logic last);
    i_data  = d;
    i_valid = 1'b1;
    i_last  = last;
    tick(1);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_n(input string tag, input int n);
    for (int i = 0; i < 40 && qu.size() < n; i++) tick(1);
    tick(2);
    chk(tag, qu.size(), n);
  endtask

  function automatic res_t pop_u();
    if (qu.size() == 0) return '0;
    return qu.pop_front();
  endfunction

  function automatic res_t pop_s();
    if (qs.size() == 0) return '0;
    return qs.pop_front();
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W*NI-1:0] d;
    logic [W-1:0]    v, bu_v, bs_v;
    logic [IW-1:0]   bu_x, bs_x;
    res_t            r;
    int              t0, nb;

    // Reset state
    tick(3);
    chk("rst_vld", bu.o_valid, 0);
    chk("rst_res", bu.o_result, 0);
    chk("rst_idx", bu.o_index, 0);
    chk("rst_ovf", bu.o_overflow, 0);
    chk("rst_vld_s", bs.o_valid, 0);
    rst = 1'b0;
    tick(1);

    // Single beat, lane 37 = 50
    qu.delete(); qs.delete();
    d = '0; d[37*W +: W] = 6'd50;
    beat(d, 1'b1);
    t0 = cyc;
    wait_n("t1_cnt", 1);
    r = pop_u();
    chk("t1_res", r.r, 50);
    chk("t1_idx", r.x, 37);
    chk("t1_ovf", r.v, 0);
    chk("t1_lat", r.c - t0, 7);

    // Tie and sign
    qu.delete(); qs.delete();
    d = '0; d[5*W +: W] = 6'h1F; d[9*W +: W] = 6'h1F; d[2*W +: W] = 6'h20;
    beat(d, 1'b1);
    wait_n("t2_cnt", 1);
    r = pop_u();
    chk("t2_res_u", r.r, 32);
    chk("t2_idx_u", r.x, 2);
    r = pop_s();
    chk("t2_res_s", r.r, 31);
    chk("t2_idx_s", r.x, 5);

    // Three-beat window, tie across beats keeps the earlier one
    qu.delete(); qs.delete();
    d = '0; d[3*W +: W] = 6'd20;  beat(d, 1'b0);
    d = '0; d[60*W +: W] = 6'd40; beat(d, 1'b0);
    d = '0; d[1*W +: W] = 6'd40;  beat(d, 1'b1);
    wait_n("t3_cnt", 1);
    r = pop_u();
    chk("t3_res_u", r.r, 40);
    chk("t3_idx_u", r.x, 124);
    r = pop_s();
    chk("t3_res_s", r.r, 20);
    chk("t3_idx_s", r.x, 3);

    // Stall mid-pipeline; beats offered during the stall are ignored
    qu.delete(); qs.delete();
    d = '0; d[10*W +: W] = 6'd33;
    beat(d, 1'b1);
    t0 = cyc;
    tick(3);
    pipe_en = 1'b0;
    d = '0; d[0 +: W] = 6'd63;
    i_data = d; i_valid = 1'b1; i_last = 1'b1;
    tick(5);
    pipe_en = 1'b1; i_valid = 1'b0; i_last = 1'b0;
    wait_n("t4_cnt", 1);
    r = pop_u();
    chk("t4_res", r.r, 33);
    chk("t4_idx", r.x, 10);
    chk("t4_lat", r.c - t0, 12);

    // Random back-to-back windows of 1..8 beats
    qu.delete(); qs.delete();
    for (int w = 0; w < 100; w++) begin
      nb = $urandom_range(1, 8);
      bu_v = '0; bs_v = '0; bu_x = '0; bs_x = '0;
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < NI; k++) begin
          v = W'($urandom_range(0, 63));
          d[k*W +: W] = v;
          if ((b == 0 && k == 0) || v > bu_v) begin
            bu_v = v; bu_x = {4'(b), 6'(k)};
          end
          if ((b == 0 && k == 0) || $signed(v) > $signed(bs_v)) begin
            bs_v = v; bs_x = {4'(b), 6'(k)};
          end
        end
        beat(d, b == nb - 1);
      end
      exp_u.push_back({bu_v, bu_x, 1'b0});
      exp_s.push_back({bs_v, bs_x, 1'b0});
    end
    wait_n("rnd_cnt", 100);
    for (int i = 0; i < 100; i++) begin
      r = pop_u();
      chk("rnd_u", {r.r, r.x, r.v}, exp_u[i]);
      r = pop_s();
      chk("rnd_s", {r.r, r.x, r.v}, exp_s[i]);
    end

    // 18-beat overflow window, then a clean 1-beat window
    qu.delete(); qs.delete();
    for (int b = 0; b < 18; b++) begin
      d = '0;
      if (b == 16) d[0 +: W] = 6'd63;
      beat(d, b == 17);
    end
    d = '0; d[4*W +: W] = 6'd7;
    beat(d, 1'b1);
    wait_n("t6_cnt", 2);
    r = pop_u();
    chk("t6_res", r.r, 63);
    chk("t6_idx", r.x, 960);
    chk("t6_ovf", r.v, 1);
    r = pop_u();
    chk("t6b_res", r.r, 7);
    chk("t6b_idx", r.x, 4);
    chk("t6b_ovf", r.v, 0);

    // Reset while a 4-beat window is partly accumulated and partly in the tree
    qu.delete(); qs.delete();
    d = '0; d[0 +: W] = 6'd60;
    beat(d, 1'b0); beat(d, 1'b0); beat(d, 1'b0);
    tick(8);
    beat(d, 1'b1);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(12);
    chk("t7_drop", qu.size(), 0);
    d = '0; d[8*W +: W] = 6'd9;
    beat(d, 1'b1);
    wait_n("t7_cnt", 1);
    r = pop_u();
    chk("t7_res", r.r, 9);
    chk("t7_idx", r.x, 8);
    chk("t7_ovf", r.v, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
